serial_adder_ctrl: RTL and testbench



---
 rtl/serial_add_pkg.sv | 13 +
 rtl/full_adder_bit.sv | 17 +
 rtl/serial_adder_ctrl.sv | 137 +++++++++++++
 tb/tb_serial_adder_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state
// encoding and the default operand width.
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage : serial_add_pkg

// File: rtl/full_adder_bit.sv
// Single-bit full adder cell. This is the one arithmetic resource that the
// serial controller time-shares across every bit position of an operation.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic half_s;

  assign half_s = a ^ b;
  assign sum    = half_s ^ cin;
  assign cout   = (a & b) | (cin & half_s);

endmodule : full_adder_bit

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller. Operands are captured on an accepted start,
// then one bit pair per clock (LSB first) goes through a single full adder
// cell, with the carry held in a flop between bits. The result is published
// to registered sum/cout together with a one-cycle done pulse.
//
// Optional feature macro: SERIAL_ADD_SUB_EN adds the sub port; when sub=1 on
// an accepted start, B is inverted and the carry starts at 1 (a - b, cout=1
// means no borrow).
module serial_adder_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int                CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]     CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]     CNT_ONE  = CW'(1);

  state_t           state_r;
  logic [WIDTH-1:0] sa_r;
  logic [WIDTH-1:0] sb_r;
  logic [WIDTH-1:0] res_r;
  logic             carry_r;
  logic [CW-1:0]    cnt_r;

  logic             s_bit_s;
  logic             c_next_s;
  logic [WIDTH-1:0] res_next_s;
  logic [WIDTH-1:0] sb_load_s;
  logic             carry_init_s;

  // The shared adder cell always sees the current LSB pair and held carry.
  full_adder_bit u_fa (
    .a    (sa_r[0]),
    .b    (sb_r[0]),
    .cin  (carry_r),
    .sum  (s_bit_s),
    .cout (c_next_s)
  );

  // New sum bit enters at the MSB; after WIDTH shifts the result is aligned.
  if (WIDTH == 1) begin : g_res_w1
    assign res_next_s = s_bit_s;
  end else begin : g_res_wn
    assign res_next_s = {s_bit_s, res_r[WIDTH-1:1]};
  end

  // Operand B and initial carry for the operation about to be accepted.
  always_comb begin
    sb_load_s    = b;
    carry_init_s = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    if (sub) begin
      sb_load_s    = ~b;
      carry_init_s = 1'b1;
    end else begin
      sb_load_s    = b;
      carry_init_s = 1'b0;
    end
`endif
  end

  // Sequencer: FSM, bit counter, shift registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      sa_r    <= '0;
      sb_r    <= '0;
      res_r   <= '0;
      carry_r <= 1'b0;
      cnt_r   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            sa_r    <= a;
            sb_r    <= sb_load_s;
            carry_r <= carry_init_s;
            cnt_r   <= '0;
            busy    <= 1'b1;
            state_r <= ST_RUN;
          end else begin
            busy    <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          sa_r    <= sa_r >> 1'd1;
          sb_r    <= sb_r >> 1'd1;
          carry_r <= c_next_s;
          res_r   <= res_next_s;
          cnt_r   <= cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            sum     <= res_next_s;
            cout    <= c_next_s;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            busy    <= 1'b1;
            done    <= 1'b0;
            state_r <= ST_RUN;
          end
        end
        ST_DONE: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : serial_adder_ctrl

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl: an 8-bit instance for
// the main scenarios and a 1-bit instance for the minimum-width case.
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
`ifdef SERIAL_ADD_SUB_EN
  logic       sub = 1'b0;
`endif
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;

  logic       start1 = 1'b0;
  logic [0:0] a1 = 1'b0;
  logic [0:0] b1 = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
  logic       sub1 = 1'b0;
`endif
  logic       busy1;
  logic       done1;
  logic [0:0] sum1;
  logic       cout1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
    .a     (a1),
    .b     (b1),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub1),
`endif
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .cout  (cout1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // After the accepting edge: wait (bounded) for done, counting cycles and busy cycles.
  task automatic wait_done(output int k, output int bcnt);
    k = 0;
    bcnt = 0;
    while (done !== 1'b1 && k < 20) begin
      if (busy === 1'b1) bcnt++;
      tick();
      k++;
    end
  endtask

  // One complete operation on the 8-bit instance with full timing checks.
  task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic [7:0] esum, input logic ecout);
    int k;
    int bcnt;
    a = ta;
    b = tb_v;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(k, bcnt);
    check_eq({tag, " latency"}, 32'(k), 32'd8);
    check_eq({tag, " busy cycles"}, 32'(bcnt), 32'd8);
    check_eq({tag, " sum"}, 32'(sum), 32'(esum));
    check_eq({tag, " cout"}, 32'(cout), 32'(ecout));
    check_eq({tag, " busy at done"}, 32'(busy), 32'd0);
    tick();
    check_eq({tag, " done drop"}, 32'(done), 32'd0);
    check_eq({tag, " sum hold"}, 32'(sum), 32'(esum));
  endtask

  initial begin
    int k;
    int bcnt;
    int ndone;
    int last;

    // Reset state
    #2;
    check_eq("rst busy", 32'(busy), 32'd0);
    check_eq("rst done", 32'(done), 32'd0);
    check_eq("rst sum", 32'(sum), 32'd0);
    check_eq("rst cout", 32'(cout), 32'd0);
    check_eq("rst busy1", 32'(busy1), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Basic add and wrap-around
    run_op("add 00+01", 8'h00, 8'h01, 8'h01, 1'b0);
    run_op("add FF+01", 8'hFF, 8'h01, 8'h00, 1'b1);
    run_op("add AA+55", 8'hAA, 8'h55, 8'hFF, 1'b0);

    // Start during busy and in the DONE cycle is ignored
    a = 8'h03;
    b = 8'h04;
    start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0;
    for (int i = 1; i <= 8; i++) begin
      if (i == 3) begin
        a = 8'h10;
        b = 8'h10;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      if (done === 1'b1) ndone++;
    end
    check_eq("ignore busy start done", 32'(ndone), 32'd1);
    check_eq("ignore busy start sum", 32'(sum), 32'h07);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("ignore done start busy", 32'(busy), 32'd0);
    tick();
    check_eq("ignore done start busy2", 32'(busy), 32'd0);

    // Reset in the middle of RUN
    a = 8'h0F;
    b = 8'h01;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    check_eq("pre-abort busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("abort busy", 32'(busy), 32'd0);
    check_eq("abort done", 32'(done), 32'd0);
    check_eq("abort sum", 32'(sum), 32'd0);
    check_eq("abort cout", 32'(cout), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done === 1'b1) ndone++;
    end
    check_eq("abort no done", 32'(ndone), 32'd0);
    run_op("after abort 0F+01", 8'h0F, 8'h01, 8'h10, 1'b0);

    // Back-to-back with start held high
    a = 8'h12;
    b = 8'h34;
    start = 1'b1;
    tick();
    ndone = 0;
    last = -1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (done === 1'b1) begin
        check_eq("b2b sum", 32'(sum), 32'h46);
        check_eq("b2b busy", 32'(busy), 32'd0);
        if (last >= 0) check_eq("b2b period", 32'(i - last), 32'd10);
        last = i;
        ndone++;
      end
    end
    check_eq("b2b done count", 32'(ndone), 32'd3);
    start = 1'b0;
    for (int i = 0; i < 12; i++) tick();

    // WIDTH=1 instance
    a1 = 1'b1;
    b1 = 1'b1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check_eq("w1 busy", 32'(busy1), 32'd1);
    check_eq("w1 done early", 32'(done1), 32'd0);
    tick();
    check_eq("w1 done", 32'(done1), 32'd1);
    check_eq("w1 sum", 32'(sum1), 32'd0);
    check_eq("w1 cout", 32'(cout1), 32'd1);
    tick();
    check_eq("w1 done drop", 32'(done1), 32'd0);
    start1 = 1'b1;
    tick();
    ndone = 0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (done1 === 1'b1) ndone++;
    end
    check_eq("w1 b2b done count", 32'(ndone), 32'd3);
    start1 = 1'b0;
    tick(); tick(); tick();

`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b1;
    run_op("sub 05-07", 8'h05, 8'h07, 8'hFE, 1'b0);
    run_op("sub 07-05", 8'h07, 8'h05, 8'h02, 1'b1);
    sub = 1'b0;
    run_op("sub0 07+05", 8'h07, 8'h05, 8'h0C, 1'b0);
`endif

    // Bounded wait sanity: an idle DUT must not produce done
    wait_done(k, bcnt);
    check_eq("idle no done", 32'(k), 32'd20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_serial_adder_ctrl
